// File: rtl/cpu_ctrl_seq_if.sv
// Memory handshake bus between the sequencer (master) and instruction/data memory (slave).
interface cpu_ctrl_seq_if;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit core.
// Drives regfile selects/strobes, ALU controls and the memory handshake.
// Optional: define CPU_CTRL_RETIRE_CNT_EN to add a 32-bit retired-instruction counter.
module cpu_ctrl_seq #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned ALU_OP_W    = 3
) (
  input  logic                clk,
  input  logic                reset,
  cpu_ctrl_seq_if.master      mem,
  input  logic                zero_in,
  output logic [2:0]          regr0s,
  output logic [2:0]          regr1s,
  output logic [2:0]          regws,
  output logic                we,
  output logic                he,
  output logic                incr_pc,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_imm,
  output logic [15:0]         imm_out,
  output logic                wb_sel,
  output logic                halted
`ifdef CPU_CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0]         retire_cnt
`endif
);

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StMem    = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;
  localparam logic [2:0] StHalt   = 3'd5;
  localparam logic [2:0] StFault  = 3'd6;

  localparam logic [3:0] OpAlu  = 4'd0;
  localparam logic [3:0] OpAddi = 4'd1;
  localparam logic [3:0] OpLui  = 4'd2;
  localparam logic [3:0] OpLd   = 4'd3;
  localparam logic [3:0] OpSt   = 4'd4;
  localparam logic [3:0] OpBrz  = 4'd5;
  localparam logic [3:0] OpHalt = 4'd15;

  localparam logic [ALU_OP_W-1:0] AluAdd   = '0;
  localparam logic [ALU_OP_W-1:0] AluPassB = ALU_OP_W'(7);

  // Counter value on the last allowed waiting cycle; the next wait trips FAULT.
  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYC - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        started_q, started_d;

  logic [3:0]  op;
  logic [2:0]  rd, rs0, rs1, fn;
  logic [15:0] imm_sext, imm_brz, imm_lui;
  logic        req;

  assign op  = ir_q[15:12];
  assign rd  = ir_q[11:9];
  assign rs0 = ir_q[8:6];
  assign rs1 = ir_q[5:3];
  assign fn  = ir_q[2:0];

  assign imm_sext = {{10{ir_q[5]}}, ir_q[5:0]};
  assign imm_brz  = {{9{ir_q[5]}}, ir_q[5:0], 1'b0};
  assign imm_lui  = {9'd0, ir_q[6:0]};

  // started_q holds outputs at zero until the first edge after reset release.
  assign req = started_q && ((state_q == StFetch) || (state_q == StMem));

  // Next state, instruction register and memory-wait timeout.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    tmo_d     = tmo_q;
    started_d = 1'b1;

    if (req) begin
      tmo_d = mem.mem_ack ? 8'd0 : tmo_q + 8'd1;
    end

    case (state_q)
      StFetch: begin
        if (req) begin
          if (mem.mem_ack) begin
            ir_d    = mem.mem_rdata;
            state_d = StDecode;
          end else if (tmo_q == TmoLast) begin
            state_d = StFault;
          end
        end
      end
      StDecode: begin
        case (op)
          OpAlu, OpAddi, OpLui, OpBrz: state_d = StExec;
          OpLd, OpSt:                  state_d = StMem;
          OpHalt:                      state_d = StHalt;
          default:                     state_d = StFault;
        endcase
      end
      StExec: state_d = StFetch;
      StMem: begin
        if (mem.mem_ack) begin
          state_d = (op == OpLd) ? StWb : StFetch;
        end else if (tmo_q == TmoLast) begin
          state_d = StFault;
        end
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase
  end

  // State registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      ir_q      <= 16'd0;
      tmo_q     <= 8'd0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      tmo_q     <= tmo_d;
      started_q <= started_d;
    end
  end

  // Moore-style control outputs decoded from state and IR (BRZ write also uses zero_in).
  always_comb begin
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    regr0s           = 3'd0;
    regr1s           = 3'd0;
    regws            = 3'd0;
    we               = 1'b0;
    he               = 1'b0;
    incr_pc          = 1'b0;
    alu_op           = AluAdd;
    alu_src_imm      = 1'b0;
    imm_out          = 16'd0;
    wb_sel           = 1'b0;
    halted           = 1'b0;

    if (started_q) begin
      case (state_q)
        StFetch: begin
          mem.mem_req = 1'b1;
        end
        StDecode: begin
          regr0s  = rs0;
          regr1s  = (op == OpSt) ? rd : rs1;
          incr_pc = 1'b1;
        end
        StExec: begin
          case (op)
            OpAlu: begin
              regr0s = rs0;
              regr1s = rs1;
              alu_op = ALU_OP_W'(fn);
              we     = 1'b1;
              regws  = rd;
            end
            OpAddi: begin
              regr0s      = rs0;
              alu_src_imm = 1'b1;
              imm_out     = imm_sext;
              we          = 1'b1;
              regws       = rd;
            end
            OpLui: begin
              alu_op      = AluPassB;
              alu_src_imm = 1'b1;
              imm_out     = imm_lui;
              we          = 1'b1;
              he          = 1'b1;
              regws       = rd;
            end
            OpBrz: begin
              regr0s      = rs0;
              regr1s      = 3'd7;
              alu_src_imm = 1'b1;
              imm_out     = imm_brz;
              if (zero_in) begin
                we    = 1'b1;
                regws = 3'd7;
              end
            end
            default: ;
          endcase
        end
        StMem: begin
          mem.mem_req      = 1'b1;
          mem.mem_addr_sel = 1'b1;
          mem.mem_we       = (op == OpSt);
          regr0s           = rs0;
          regr1s           = (op == OpSt) ? rd : 3'd0;
          alu_src_imm      = 1'b1;
          imm_out          = imm_sext;
        end
        StWb: begin
          we     = 1'b1;
          wb_sel = 1'b1;
          regws  = rd;
        end
        StHalt, StFault: begin
          halted = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CPU_CTRL_RETIRE_CNT_EN
  logic [31:0] retire_q, retire_d;

  // Count an instruction on its final cycle: EXEC, WB, or the acked MEM cycle of a store.
  always_comb begin
    retire_d = retire_q;
    if (started_q && ((state_q == StExec) || (state_q == StWb) ||
        ((state_q == StMem) && mem.mem_ack && (op == OpSt)))) begin
      retire_d = retire_q + 32'd1;
    end
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_q <= 32'd0;
    end else begin
      retire_q <= retire_d;
    end
  end

  assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench for cpu_ctrl_seq: directed instructions from the plan plus random ones,
// checked cycle by cycle against an instruction-level schedule model.
module tb_cpu_ctrl_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        zero_in;
  logic [2:0]  regr0s, regr1s, regws;
  logic        we, he, incr_pc, alu_src_imm, wb_sel, halted;
  logic [2:0]  alu_op;
  logic [15:0] imm_out;
`ifdef CPU_CTRL_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_retire = 0;

  always #5 clk = ~clk;

  cpu_ctrl_seq_if bus ();

  cpu_ctrl_seq #(
    .TIMEOUT_CYC (255),
    .ALU_OP_W    (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem         (bus),
    .zero_in     (zero_in),
    .regr0s      (regr0s),
    .regr1s      (regr1s),
    .regws       (regws),
    .we          (we),
    .he          (he),
    .incr_pc     (incr_pc),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .imm_out     (imm_out),
    .wb_sel      (wb_sel),
    .halted      (halted)
`ifdef CPU_CTRL_RETIRE_CNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] sext6(input logic [15:0] ir);
    int v;
    v = int'(ir[5:0]);
    if (v >= 32) v = v - 64;
    return 16'(v);
  endfunction

  function automatic logic [31:0] all_outs();
    return {bus.mem_req, bus.mem_we, bus.mem_addr_sel, regr0s, regr1s, regws, we, he,
            incr_pc, alu_op, alu_src_imm, wb_sel, halted};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_outs", all_outs(), 32'd0);
    check("rst_imm", imm_out, 16'd0);
    @(negedge clk);
    // A stray ack carrying HALT before the first request must be ignored.
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hF000;
    reset         = 1'b0;
    #1;
    check("rel_req_low", bus.mem_req, 1'b0);
    exp_retire = 0;
  endtask

  task automatic fetch(input logic [15:0] ir, input int fw);
    for (int i = 0; i <= fw; i++) begin
      @(negedge clk);
      bus.mem_ack   = (i == fw);
      bus.mem_rdata = (i == fw) ? ir : 16'($urandom);
      zero_in       = 1'($urandom);
      #1;
      check("fetch_req", bus.mem_req, 1'b1);
      check("fetch_addr_sel", bus.mem_addr_sel, 1'b0);
      check("fetch_mem_we", bus.mem_we, 1'b0);
      check("fetch_we", we, 1'b0);
`ifdef CPU_CTRL_RETIRE_CNT_EN
      if (i == 0) check("retire_cnt", retire_cnt, 32'(exp_retire));
`endif
    end
  endtask

  task automatic run_instr(input logic [15:0] ir, input bit z, input int fw, input int mw);
    int op;
    logic [2:0] rd, rs0, rs1, fn;
    bit exp_we;
    op  = int'(ir[15:12]);
    rd  = ir[11:9];
    rs0 = ir[8:6];
    rs1 = ir[5:3];
    fn  = ir[2:0];
    fetch(ir, fw);

    @(negedge clk);
    bus.mem_ack   = 1'($urandom);
    bus.mem_rdata = 16'($urandom);
    #1;
    check("dec_incr_pc", incr_pc, 1'b1);
    check("dec_we", we, 1'b0);
    check("dec_req", bus.mem_req, 1'b0);
    check("dec_regr0s", regr0s, rs0);
    check("dec_regr1s", regr1s, (op == 4) ? rd : rs1);

    if (op == 0 || op == 1 || op == 2 || op == 5) begin
      @(negedge clk);
      zero_in     = z;
      bus.mem_ack = 1'($urandom);
      #1;
      exp_we = (op != 5) || z;
      check("ex_we", we, exp_we);
      if (exp_we) check("ex_regws", regws, (op == 5) ? 3'd7 : rd);
      check("ex_he", he, op == 2);
      check("ex_incr_pc", incr_pc, 1'b0);
      check("ex_req", bus.mem_req, 1'b0);
      check("ex_src_imm", alu_src_imm, op != 0);
      if (op == 0) begin
        check("ex_alu_op", alu_op, fn);
        check("ex_regr1s", regr1s, rs1);
      end
      if (op == 0 || op == 1) check("ex_wb_sel", wb_sel, 1'b0);
      if (op == 1) check("ex_imm_addi", imm_out, sext6(ir));
      if (op == 2) check("ex_imm_lui", imm_out, {9'd0, ir[6:0]});
      if (op == 5) begin
        check("ex_imm_brz", imm_out, 16'(sext6(ir) * 2));
        check("ex_brz_regr1s", regr1s, 3'd7);
      end
      if (op != 2) check("ex_regr0s", regr0s, rs0);
      exp_retire++;
    end else if (op == 3 || op == 4) begin
      for (int j = 0; j <= mw; j++) begin
        @(negedge clk);
        bus.mem_ack   = (j == mw);
        bus.mem_rdata = 16'($urandom);
        zero_in       = 1'($urandom);
        #1;
        check("mem_req", bus.mem_req, 1'b1);
        check("mem_addr_sel", bus.mem_addr_sel, 1'b1);
        check("mem_we", bus.mem_we, op == 4);
        check("mem_rf_we", we, 1'b0);
        check("mem_incr_pc", incr_pc, 1'b0);
        check("mem_imm", imm_out, sext6(ir));
        check("mem_regr0s", regr0s, rs0);
        check("mem_src_imm", alu_src_imm, 1'b1);
        if (op == 4) check("mem_st_regr1s", regr1s, rd);
      end
      if (op == 3) begin
        @(negedge clk);
        bus.mem_ack = 1'($urandom);
        #1;
        check("wb_we", we, 1'b1);
        check("wb_sel", wb_sel, 1'b1);
        check("wb_regws", regws, rd);
        check("wb_req", bus.mem_req, 1'b0);
        check("wb_incr_pc", incr_pc, 1'b0);
      end
      exp_retire++;
    end else begin
      repeat (3) begin
        @(negedge clk);
        bus.mem_ack   = 1'($urandom);
        bus.mem_rdata = 16'($urandom);
        #1;
        check("stop_halted", halted, 1'b1);
        check("stop_req", bus.mem_req, 1'b0);
        check("stop_we", we, 1'b0);
        check("stop_incr_pc", incr_pc, 1'b0);
        check("stop_he", he, 1'b0);
      end
`ifdef CPU_CTRL_RETIRE_CNT_EN
      check("stop_retire", retire_cnt, 32'(exp_retire));
`endif
    end
  endtask

  // incr_pc must never coincide with any regfile write.
  always @(negedge clk) begin
    #2;
    if (!reset && incr_pc) check("pc_we_overlap", we, 1'b0);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    int cnt;
    int op;
    logic [15:0] r;
    reset         = 1'b1;
    zero_in       = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'd0;
    do_reset();

    run_instr(16'h1245, 1'b0, 0, 0);
    run_instr(16'h3A81, 1'b0, 0, 2);
    run_instr(16'h507E, 1'b1, 0, 0);
    run_instr(16'h507E, 1'b0, 1, 0);
    run_instr(16'h2C7F, 1'b0, 0, 0);
    run_instr(16'h4283, 1'b0, 2, 1);

    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 5));
      r  = 16'($urandom);
      run_instr({4'(op), r[11:0]}, 1'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
    end

    run_instr(16'hF000, 1'b0, 0, 0);
    do_reset();
    run_instr(16'h7123, 1'b0, 1, 0);
    do_reset();

    // Fetch never acked: count request cycles until FAULT.
    cnt = 0;
    for (int i = 0; i < 300 && !halted; i++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      #1;
      if (bus.mem_req) cnt++;
    end
    check("tmo_cycles", 32'(cnt), 32'd255);
    check("tmo_halted", halted, 1'b1);
    do_reset();

    // Reset in the middle of a store's MEM phase.
    run_instr(16'h1245, 1'b0, 0, 0);
    fetch(16'h4283, 0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    check("mid_st_we", bus.mem_we, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_outs", all_outs(), 32'd0);
    check("mid_rst_imm", imm_out, 16'd0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    reset       = 1'b0;
    exp_retire  = 0;
    run_instr(16'h2C7F, 1'b0, 0, 0);
    run_instr(16'h3A81, 1'b0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
Multi-cycle fetch/decode/execute sequencer for the 16-bit core. It sits directly upstream of the register file. It drives the regfile read selects, write select, `we`, `he` and `incr_pc`, plus the ALU and memory-bus controls. It consumes the instruction word returned over the memory handshake and a zero flag from the datapath.

Parameters:
TIMEOUT_CYC, 255, max cycles mem_req may wait for mem_ack before entering FAULT (8-bit counter).
ALU_OP_W, 3, width of alu_op.

Ports:
clk  in  1  core clock; all state updates on posedge.
reset  in  1  asynchronous, active-high; clears all state immediately.
mem_rdata  in  16  instruction or load data, valid when mem_ack=1.
mem_ack  in  1  memory transfer complete; ignored while mem_req=0.
zero_in  in  1  datapath flag: regr0 == 0.
mem_req  out  1  memory request.
mem_we  out  1  1=store, 0=read.
mem_addr_sel  out  1  0=address from R7 (PC), 1=address from ALU result.
regr0s  out  3  regfile read select 0.
regr1s  out  3  regfile read select 1.
regws  out  3  regfile write select.
we  out  1  regfile write enable.
he  out  1  high-part write (regw[6:0] -> Rd[15:9]).
incr_pc  out  1  R7 += 2.
alu_op  out  ALU_OP_W  ALU function.
alu_src_imm  out  1  ALU operand B = imm_out instead of regr1.
imm_out  out  16  sign-extended immediate.
wb_sel  out  1  regw source: 0=ALU, 1=mem_rdata.
halted  out  1  HALT or FAULT reached.

Behaviour:
- Reset values:
  - All outputs 0.
  - State=FETCH, IR=0, timeout counter=0.
  - mem_req rises on the first posedge after reset releases.
- Instruction fields:
  - op=IR[15:12], rd=IR[11:9], rs0=IR[8:6], rs1=IR[5:3], fn=IR[2:0], imm6=IR[5:0], imm7=IR[6:0].
- Opcodes:
  - 0=ALU: rd=rs0 fn rs1.
  - 1=ADDI: rd=rs0+sext(imm6).
  - 2=LUI: rd[15:9]=imm7.
  - 3=LD: rd=M[rs0+sext(imm6)].
  - 4=ST: M[rs0+sext(imm6)]=rd.
  - 5=BRZ: if rs0==0, R7=R7+(sext(imm6)<<1).
  - 15=HALT.
  - Any other opcode -> FAULT.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.
- FETCH:
  - Outputs: mem_req=1, mem_we=0, mem_addr_sel=0.
  - On a posedge with mem_ack=1: IR<=mem_rdata, go to DECODE.
- DECODE:
  - Drive regr0s/regr1s from IR and incr_pc=1 (exactly one cycle per instruction).
  - For ST, regr1s=rd.
  - Next state: EXEC for ALU/ADDI/LUI/BRZ; MEM for LD/ST; HALT; FAULT.
- EXEC:
  - we=1, regws=rd, wb_sel=0 for ALU/ADDI.
  - LUI: we=1, he=1, alu_op=PASS_B, imm_out=imm7 zero-extended.
  - BRZ: regr0s=rs0, and regr1s=7 with alu_src_imm so the ALU computes R7+imm. zero_in is sampled this cycle; taken -> we=1, regws=7; not taken -> we=0.
  - Next state: FETCH.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=(op==ST); ALU computes rs0+imm_out.
  - On mem_ack: LD -> WB, ST -> FETCH.
- WB:
  - we=1, wb_sel=1, regws=rd; mem_rdata is held valid by memory through WB.
  - Next state: FETCH.
- Regfile writes land on the negedge of the cycle in which `we` is high.
- incr_pc and we with regws=7 are never asserted in the same cycle; the regfile's incr_pc would override the write.
- rd=0: we is still asserted; the regfile discards the write. No special-casing.
- Latency with mem_ack in the first request cycle:
  - ALU/ADDI/LUI/BRZ: 3 cycles.
  - ST: 3 cycles.
  - LD: 4 cycles.
- Each extra memory wait cycle adds 1.
- Handshake:
  - mem_req, mem_we and mem_addr_sel stay stable until the ack posedge.
  - mem_req drops the following cycle.
  - Back-to-back fetches are separated by at least DECODE.
- Timeout:
  - Counter increments each cycle mem_req=1 and mem_ack=0; it clears on ack.
  - Reaching TIMEOUT_CYC -> FAULT.
- HALT/FAULT:
  - halted=1, all strobes 0.
  - Exit only via reset.
- Reset asserted mid-operation:
  - Outputs go to 0 immediately (asynchronous); no partial write is issued.
  - The regfile itself clears R7 on reset.

Optional Feature:
CPU_CTRL_RETIRE_CNT_EN
- Defined:
  - Adds output retire_cnt (32 bits), cleared by reset.
  - Increments by 1 on the last cycle of each instruction: EXEC, WB, or MEM-with-ack for ST.
  - HALT and FAULT do not increment it.
  - Wraps 0xFFFFFFFF -> 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then mem_rdata=0x1245 (ADDI r1,r1,5) acked on the first cycle:
  - mem_req at cycle 1.
  - DECODE: incr_pc=1, regr0s=1.
  - EXEC: we=1, regws=1, alu_src_imm=1, imm_out=0x0005.
  - Back to FETCH; 3 cycles total.
- LD 0x3A81 (r5=M[r2+1]) with mem_ack delayed 2 cycles in MEM:
  - mem_addr_sel=1 and mem_we=0 held stable for 3 cycles.
  - WB: we=1, wb_sel=1, regws=5.
  - 6 cycles total.
- BRZ 0x507E (r1, imm=-2):
  - zero_in=1: EXEC gives we=1, regws=7, imm_out=0xFFFC.
  - zero_in=0: we=0.
  - incr_pc never coincides with we.
- LUI 0x2C7F: EXEC gives we=1, he=1, regws=6, imm_out=0x007F.
- Fetch with mem_ack held 0: FAULT and halted=1 after TIMEOUT_CYC=255 waiting cycles. Opcode 0x7 also gives FAULT; 0xF gives HALT with no strobes.
- Assert reset during MEM of a ST: outputs 0 that same cycle; after release, fetch restarts with mem_addr_sel=0.
